result_wb_buffer: RTL and testbench
===================================

Name: result_wb_buffer

Overview:
- Receiving end of the RES_UOp result interface driven by multi-cycle execution units (multiplier, divider).
- These units cannot stall mid-pipeline, so their results are queued here before going onto a shared writeback port that a higher-priority unit may occupy.
- Queued entries are squashed on branch mispredict by sqN age.
- Backpressure goes to the unit's issue side through OUT_busy.

Parameters:
- DEPTH, 8, number of FIFO entries (power of two, ≥2).
- INFLIGHT, 5, maximum results the producing unit can still deliver after OUT_busy asserts (its pipeline stages + output register).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- IN_branch  in  BranchProv  branch/flush broadcast (taken, sqN).
- IN_uop  in  RES_UOp  result from the execution unit (valid, tagDst, nmDst, sqN, result, flags, doNotCommit).
- IN_wbStall  in  1  shared writeback port is taken this cycle; do not pop.
- OUT_busy  out  1  unit must not issue new ops.
- OUT_uop  out  RES_UOp  registered result to the writeback port.

Behaviour:
- Storage: circular FIFO of DEPTH entries.
  - Each entry holds the full RES_UOp payload plus a live bit.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is $clog2(DEPTH+1) bits.
- Reset (rst=0, async):
  - count, read pointer and write pointer clear to 0.
  - All live bits clear.
  - OUT_uop.valid=0, with other OUT_uop fields don't-care.
  - OUT_busy=0 follows from count=0.
  - Reset mid-operation discards all queued entries; nothing is emitted.
- Kill condition (one rule used everywhere): an sqN is killed when IN_branch.taken and $signed(sqN - IN_branch.sqN) > 0.
  - Equal sqN is not killed.
  - Wrap-around is handled by the signed difference.
- Enqueue:
  - Happens at a posedge when IN_uop.valid and IN_uop.sqN is not killed.
  - The payload is written at the write pointer with live=1, and the pointer increments.
  - A killed input is dropped and does not occupy an entry.
- Flush: on any cycle with IN_branch.taken, every stored entry whose sqN is killed has live cleared.
  - Cleared entries still occupy slots until popped.
  - Entries are not compacted, because ordering by sqN is not guaranteed.
- Dequeue at the head, one per cycle, when count>0:
  - Head not live (or killed this cycle): the entry is popped regardless of IN_wbStall; nothing is emitted.
  - Head live, not killed, IN_wbStall=0: the entry is popped and OUT_uop is loaded with the payload, valid=1.
  - Head live and IN_wbStall=1: no pop.
- OUT_uop is valid for exactly one cycle per emitted result. On every cycle with no emit, OUT_uop.valid=0.
- Latency: an input sampled at edge E0 is emitted at edge E1 at the earliest, i.e. valid during the cycle after E1.
  - Minimum is 2 cycles from IN_uop presentation to OUT_uop visibility.
  - Each stalled cycle adds 1.
- Order: live results leave in arrival order.
- Simultaneous enqueue and dequeue: allowed in any state, including count=DEPTH; count is unchanged.
- count update: count_next = count + enq - deq.
- OUT_busy: combinational, asserted when DEPTH - count ≤ INFLIGHT.
  - This guarantees in-flight results always fit.
- Overflow: enqueue when count=DEPTH with no pop is a protocol violation.
  - A simulation assertion fires.
  - The input is dropped; FIFO state is not corrupted.
- Empty: no emit; OUT_uop.valid=0.
- No combinational path from IN_uop or IN_wbStall to OUT_uop.

Test Plan:
- Single result: IN_uop valid sqN=10 result=0x1234 for 1 cycle, IN_wbStall=0 → OUT_uop.valid 2 cycles later, result=0x1234, sqN=10, one cycle only; count returns to 0.
- Stall hold: enqueue sqN 1,2,3 back-to-back with IN_wbStall=1 for 5 cycles → no OUT_uop.valid during the stall; then sqN 1,2,3 emitted on 3 consecutive cycles.
- Backpressure: fill with IN_wbStall=1 (DEPTH=8, INFLIGHT=5) → OUT_busy rises when count=3. Then 5 further results are accepted, reaching count=8, with no assertion. Enqueue and pop in the same cycle at full keeps count=8.
- Flush: queue sqN 4,9,6,12 under stall, then IN_branch.taken sqN=6, release stall → only 4 and 6 emitted. 9 and 12 are popped silently in 1 cycle each.
- Flush vs input: IN_uop sqN=20 arrives on the same cycle as IN_branch.taken sqN=15 → not enqueued, count unchanged. With sqN=15 → enqueued and later emitted.
- Reset mid-operation: 4 entries queued, deassert rst asynchronously between edges → OUT_uop.valid=0 immediately, count=0, OUT_busy=0. No queued entry is ever emitted after release.

Source files
------------

// File: rtl/result_wb_buffer.sv
// ---------------------------------------------------------------------------
// result_wb_buffer
//
// Queues results from a multi-cycle execution unit (multiplier, divider) that
// cannot stall mid-pipeline, and hands them one per cycle to a shared
// writeback port that a higher-priority unit may occupy. Entries younger than
// a taken branch are squashed in place; backpressure reaches the unit's issue
// side early enough that every result already in flight still fits.
//
// Ports
//   clk         clock
//   rst         asynchronous reset, active-low
//   IN_branch   branch/flush broadcast (taken, sqN)
//   IN_uop      result from the execution unit
//   IN_wbStall  shared writeback port is taken this cycle; head must wait
//   OUT_busy    unit must not issue new ops
//   OUT_uop     registered result to the writeback port
// ---------------------------------------------------------------------------
package result_wb_pkg;
    localparam int SQN_W = 7;
    localparam int TAG_W = 7;
    localparam int NM_W  = 5;
    localparam int RES_W = 32;
    localparam int FLG_W = 4;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tagDst;
        logic [NM_W-1:0]  nmDst;
        logic [SQN_W-1:0] sqN;
        logic [RES_W-1:0] result;
        logic [FLG_W-1:0] flags;
        logic             doNotCommit;
    } RES_UOp;

    typedef struct packed {
        logic             taken;
        logic [SQN_W-1:0] sqN;
    } BranchProv;
endpackage

module result_wb_buffer
    import result_wb_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int INFLIGHT = 5
) (
    input  logic      clk,
    input  logic      rst,
    input  BranchProv IN_branch,
    input  RES_UOp    IN_uop,
    input  logic      IN_wbStall,
    output logic      OUT_busy,
    output RES_UOp    OUT_uop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // An op is younger than the branch when the wrapped difference is
    // strictly positive: top bit clear and not zero. Equal sqN survives.
    function automatic logic is_killed(input logic [SQN_W-1:0] sqn,
                                       input BranchProv        br);
        logic [SQN_W-1:0] diff;
        diff = sqn - br.sqN;
        return br.taken && !diff[SQN_W-1] && (diff != '0);
    endfunction

    RES_UOp           mem_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    RES_UOp           out_q;

    RES_UOp head_uop;
    logic   head_ok;
    logic   not_empty;
    logic   full;
    logic   enq_req;
    logic   enq;
    logic   deq;
    logic   emit;

    always_comb begin
        head_uop  = mem_q[rd_ptr_q];
        head_ok   = live_q[rd_ptr_q] && !is_killed(head_uop.sqN, IN_branch);
        not_empty = (count_q != '0);
        full      = (count_q == CNT_W'(DEPTH));

        // A dead head is discarded even while the writeback port is busy,
        // so squashed entries never hold up the queue.
        deq  = not_empty && (!head_ok || !IN_wbStall);
        emit = not_empty && head_ok && !IN_wbStall;

        enq_req = IN_uop.valid && !is_killed(IN_uop.sqN, IN_branch);
        // At full, a same-cycle pop frees the slot the write lands in.
        enq     = enq_req && (!full || deq);

        // Squash in place; killed entries keep their slot until popped
        // because stored sqNs are not sorted.
        for (int i = 0; i < DEPTH; i++) begin
            live_d[i] = live_q[i] && !is_killed(mem_q[i].sqN, IN_branch);
        end
        if (deq) live_d[rd_ptr_q] = 1'b0;
        if (enq) live_d[wr_ptr_q] = 1'b1;

        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    // Free slots must cover everything the unit can still deliver.
    assign OUT_busy = (CNT_W'(DEPTH) - count_q) <= CNT_W'(INFLIGHT);
    assign OUT_uop  = out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (emit) begin
                out_q       <= head_uop;
                out_q.valid <= 1'b1;
            end else begin
                out_q.valid <= 1'b0;
            end
        end
    end

    // Payload storage carries no reset; the live bits decide what is real.
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= IN_uop;
    end

    // The producer must honour OUT_busy; a push into a full queue with no
    // pop is dropped above and flagged here.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                    !(enq_req && full && !deq));

endmodule

// File: tb/tb_result_wb_buffer.sv
module tb_result_wb_buffer;
    import result_wb_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    BranchProv IN_branch;
    RES_UOp    IN_uop;
    logic      IN_wbStall;
    logic      OUT_busy;
    RES_UOp    OUT_uop;

    int     n_checks = 0;
    int     n_pass   = 0;
    RES_UOp sb_q[$];
    RES_UOp mon_exp;

    always #5 clk = ~clk;

    result_wb_buffer #(.DEPTH(8), .INFLIGHT(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .IN_branch  (IN_branch),
        .IN_uop     (IN_uop),
        .IN_wbStall (IN_wbStall),
        .OUT_busy   (OUT_busy),
        .OUT_uop    (OUT_uop)
    );

    function automatic RES_UOp mk_uop(input logic [6:0] sqn, input logic [31:0] res);
        RES_UOp u;
        u.valid       = 1'b1;
        u.tagDst      = sqn ^ 7'h55;
        u.nmDst       = sqn[4:0] + 5'd3;
        u.sqN         = sqn;
        u.result      = res;
        u.flags       = sqn[3:0];
        u.doNotCommit = sqn[0];
        return u;
    endfunction

    // Reference kill rule: wrap the integer difference into [-64,63].
    function automatic bit tb_killed(input int sqn, input int br);
        int d;
        d = sqn - br;
        if (d > 63)  d -= 128;
        if (d < -64) d += 128;
        return d > 0;
    endfunction

    function automatic void sb_flush(input int br);
        RES_UOp keep[$];
        foreach (sb_q[i]) if (!tb_killed(int'(sb_q[i].sqN), br)) keep.push_back(sb_q[i]);
        sb_q = keep;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every emitted result must be the oldest expected one.
    always @(negedge clk) begin
        if (OUT_uop.valid === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: emitted sqN=%0d, required no output", OUT_uop.sqN);
            end else begin
                mon_exp = sb_q.pop_front();
                if (OUT_uop !== mon_exp)
                    $display("FAIL sb_payload: got %h, required %h", OUT_uop, mon_exp);
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", OUT_uop.valid); else n_pass++;
        n_checks++; if (OUT_busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", OUT_busy); else n_pass++;
        n_checks++; if (dut.count_q !== 4'd0) $display("FAIL rst_count: got %0d, required 0", dut.count_q); else n_pass++;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL rst_release_valid: got %b, required 0", OUT_uop.valid); else n_pass++;
    endtask

    task automatic test_single();
        IN_uop = mk_uop(7'd10, 32'h1234);
        sb_q.push_back(IN_uop);
        tick();
        IN_uop = '0;
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL single_early: valid got %b, required 0", OUT_uop.valid); else n_pass++;
        n_checks++; if (dut.count_q !== 4'd1) $display("FAIL single_count1: got %0d, required 1", dut.count_q); else n_pass++;
        tick();
        n_checks++; if (OUT_uop.valid !== 1'b1 || OUT_uop.result !== 32'h1234 || OUT_uop.sqN !== 7'd10)
            $display("FAIL single_emit: valid=%b result=%h sqN=%0d, required 1/1234/10", OUT_uop.valid, OUT_uop.result, OUT_uop.sqN);
        else n_pass++;
        tick();
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL single_one_cycle: valid got %b, required 0", OUT_uop.valid); else n_pass++;
        n_checks++; if (dut.count_q !== 4'd0) $display("FAIL single_count0: got %0d, required 0", dut.count_q); else n_pass++;
    endtask

    task automatic test_stall();
        IN_wbStall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 3) begin
                IN_uop = mk_uop(7'(i), 32'hA000 + 32'(i));
                sb_q.push_back(IN_uop);
            end else IN_uop = '0;
            tick();
            n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL stall_hold%0d: valid got %b, required 0", i, OUT_uop.valid); else n_pass++;
        end
        n_checks++; if (dut.count_q !== 4'd3) $display("FAIL stall_count: got %0d, required 3", dut.count_q); else n_pass++;
        IN_wbStall = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (OUT_uop.valid !== 1'b1 || OUT_uop.sqN !== 7'(i))
                $display("FAIL stall_release%0d: valid=%b sqN=%0d, required 1/%0d", i, OUT_uop.valid, OUT_uop.sqN, i);
            else n_pass++;
        end
        tick();
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL stall_after: valid got %b, required 0", OUT_uop.valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        IN_wbStall = 1'b1;
        n_checks++; if (OUT_busy !== 1'b0) $display("FAIL bp_empty_busy: got %b, required 0", OUT_busy); else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            IN_uop = mk_uop(7'(29 + k), $urandom);
            sb_q.push_back(IN_uop);
            tick();
            n_checks++; if (dut.count_q !== 4'(k)) $display("FAIL bp_count%0d: got %0d, required %0d", k, dut.count_q, k); else n_pass++;
            n_checks++; if (OUT_busy !== (k >= 3)) $display("FAIL bp_busy%0d: got %b, required %b", k, OUT_busy, (k >= 3)); else n_pass++;
        end
        IN_wbStall = 1'b0;
        IN_uop = mk_uop(7'd38, 32'hBEEF0038);
        sb_q.push_back(IN_uop);
        tick();
        IN_uop = '0;
        n_checks++; if (dut.count_q !== 4'd8) $display("FAIL bp_full_swap_count: got %0d, required 8", dut.count_q); else n_pass++;
        n_checks++; if (OUT_uop.valid !== 1'b1 || OUT_uop.sqN !== 7'd30)
            $display("FAIL bp_full_swap_emit: valid=%b sqN=%0d, required 1/30", OUT_uop.valid, OUT_uop.sqN);
        else n_pass++;
        for (int j = 0; j < 8; j++) tick();
        n_checks++; if (dut.count_q !== 4'd0) $display("FAIL bp_drain_count: got %0d, required 0", dut.count_q); else n_pass++;
        n_checks++; if (OUT_busy !== 1'b0) $display("FAIL bp_drain_busy: got %b, required 0", OUT_busy); else n_pass++;
    endtask

    task automatic test_flush();
        int  sq[4]  = '{4, 9, 6, 12};
        bit  exp_v[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        IN_wbStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IN_uop = mk_uop(7'(sq[i]), 32'hF000 + 32'(sq[i]));
            sb_q.push_back(IN_uop);
            tick();
        end
        IN_uop = '0;
        IN_branch.taken = 1'b1;
        IN_branch.sqN   = 7'd6;
        sb_flush(6);
        tick();
        IN_branch = '0;
        n_checks++; if (dut.count_q !== 4'd4) $display("FAIL flush_slots_kept: got %0d, required 4", dut.count_q); else n_pass++;
        IN_wbStall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (OUT_uop.valid !== exp_v[i]) $display("FAIL flush_pop%0d: valid got %b, required %b", i, OUT_uop.valid, exp_v[i]); else n_pass++;
        end
        n_checks++; if (dut.count_q !== 4'd0) $display("FAIL flush_count: got %0d, required 0", dut.count_q); else n_pass++;
    endtask

    task automatic test_flush_input();
        int br[4]  = '{15, 15, 120, 120};
        int sq[4]  = '{20, 15, 2, 100};
        for (int i = 0; i < 4; i++) begin
            bit keep;
            keep = !tb_killed(sq[i], br[i]);
            IN_branch.taken = 1'b1;
            IN_branch.sqN   = 7'(br[i]);
            IN_uop = mk_uop(7'(sq[i]), 32'hC000 + 32'(sq[i]));
            if (keep) sb_q.push_back(IN_uop);
            tick();
            IN_branch = '0;
            IN_uop    = '0;
            n_checks++; if (dut.count_q !== 4'(keep)) $display("FAIL flushin_count%0d: got %0d, required %0d", i, dut.count_q, keep); else n_pass++;
            tick();
            n_checks++; if (OUT_uop.valid !== keep) $display("FAIL flushin_emit%0d: valid got %b, required %b", i, OUT_uop.valid, keep); else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        IN_wbStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IN_uop = mk_uop(7'(40 + i), 32'hD000 + 32'(i));
            sb_q.push_back(IN_uop);
            tick();
        end
        IN_uop = '0;
        IN_wbStall = 1'b0;
        tick();
        n_checks++; if (OUT_uop.valid !== 1'b1 || OUT_busy !== 1'b1)
            $display("FAIL rmid_before: valid=%b busy=%b, required 1/1", OUT_uop.valid, OUT_busy);
        else n_pass++;
        #2 rst = 1'b0;
        sb_q.delete();
        #1;
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL rmid_valid: got %b, required 0", OUT_uop.valid); else n_pass++;
        n_checks++; if (OUT_busy !== 1'b0) $display("FAIL rmid_busy: got %b, required 0", OUT_busy); else n_pass++;
        n_checks++; if (dut.count_q !== 4'd0) $display("FAIL rmid_count: got %0d, required 0", dut.count_q); else n_pass++;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL rmid_quiet%0d: valid got %b, required 0", i, OUT_uop.valid); else n_pass++;
        end
    endtask

    initial begin
        IN_branch  = '0;
        IN_uop     = '0;
        IN_wbStall = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_backpressure();
        test_flush();
        test_flush_input();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL sb_leftover: %0d results never emitted, required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
